// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach intersection controller with pedestrian crossings.
// Timing advances on an external tick enable; request debounce runs every clk.
module traffic_phase_ctrl #(
  parameter int N_PHASES      = 2,
  parameter int T_ALL_RED     = 20,
  parameter int T_RED_YELLOW  = 10,
  parameter int T_GREEN       = 150,
  parameter int T_MIN_GREEN   = 50,
  parameter int T_GREEN_BLINK = 40,
  parameter int T_YELLOW      = 30,
  parameter int BLINK_HALF    = 5,
  parameter int DEBOUNCE_CYC  = 50,
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                enable,
  input  logic [N_PHASES-1:0] ped_req,
  output logic [N_PHASES-1:0] car_red,
  output logic [N_PHASES-1:0] car_yellow,
  output logic [N_PHASES-1:0] car_green,
  output logic [N_PHASES-1:0] ped_red,
  output logic [N_PHASES-1:0] ped_green,
  output logic [PW-1:0]       active_phase,
  output logic [7:0]          rem_ticks,
  output logic [N_PHASES-1:0] req_pending
);

  localparam int TW = 16;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_ALL_RED,
    S_RED_YELLOW,
    S_GREEN,
    S_GREEN_BLINK,
    S_YELLOW
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic [N_PHASES-1:0] pend_q, pend_d;
  logic [N_PHASES-1:0] srv, walk, hit;
  logic [N_PHASES-1:0] set_req, clr_req;

  logic          clr_all, clr_srv;
  logic          in_grn, last, early, adv;
  logic [TW-1:0] dur_q, rem_full;

  function automatic logic [TW-1:0] dur_of(input state_t s);
    logic [TW-1:0] d;
    d = TW'(1);
    case (s)
      S_ALL_RED:     d = TW'(T_ALL_RED);
      S_RED_YELLOW:  d = TW'(T_RED_YELLOW);
      S_GREEN:       d = TW'(T_GREEN);
      S_GREEN_BLINK: d = TW'(T_GREEN_BLINK);
      S_YELLOW:      d = TW'(T_YELLOW);
      default:       d = TW'(1);
    endcase
    return d;
  endfunction

  assign dur_q  = dur_of(state_q);
  assign in_grn = (state_q == S_GREEN) || (state_q == S_GREEN_BLINK);
  assign walk   = srv & {N_PHASES{in_grn}};
  assign last   = (timer_q == dur_q - TW'(1));

  // A waiting crossing other than the one walking now cuts green short.
  assign early = (state_q == S_GREEN)
              && (timer_q >= TW'(T_MIN_GREEN - 1))
              && (|(pend_q & ~srv));
  assign adv   = last || early;

  for (genvar k = 0; k < N_PHASES; k++) begin : g_xing
    localparam logic [PW-1:0] SK = PW'((k + 1) % N_PHASES);
    logic [DW-1:0] cnt_q;

    assign srv[k] = (phase_q == SK);
    assign hit[k] = (cnt_q == DW'(DEBOUNCE_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (!ped_req[k]) begin
        cnt_q <= '0;
      end else if (!hit[k]) begin
        cnt_q <= cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    clr_all = 1'b0;
    clr_srv = 1'b0;
    if (tick) begin
      if (state_q == S_OFF) begin
        if (enable) begin
          state_d = S_ALL_RED;
          timer_d = '0;
          phase_d = '0;
        end
      end else if (!enable) begin
        state_d = S_OFF;
        timer_d = '0;
        phase_d = '0;
        clr_all = 1'b1;
      end else if (adv) begin
        timer_d = '0;
        unique case (state_q)
          S_ALL_RED:     state_d = S_RED_YELLOW;
          S_RED_YELLOW: begin
            state_d = S_GREEN;
            clr_srv = 1'b1;
          end
          S_GREEN:       state_d = S_GREEN_BLINK;
          S_GREEN_BLINK: state_d = S_YELLOW;
          S_YELLOW: begin
            state_d = S_ALL_RED;
            phase_d = (phase_q == PW'(N_PHASES - 1))
                    ? '0 : phase_q + PW'(1);
          end
          default:       state_d = S_OFF;
        endcase
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Blink only runs while dwelling in a blinking state; entry restarts it at 0.
  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (tick) begin
      if (state_d == state_q &&
          (state_q == S_OFF || state_q == S_GREEN_BLINK)) begin
        if (bcnt_q == BW'(BLINK_HALF - 1)) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end else begin
        bcnt_d  = '0;
        blink_d = 1'b0;
      end
    end
  end

  always_comb begin
    set_req = hit & ~walk & {N_PHASES{state_q != S_OFF}};
    clr_req = {N_PHASES{clr_all}} | (srv & {N_PHASES{clr_srv}});
    pend_d  = (pend_q | set_req) & ~clr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      timer_q <= '0;
      phase_q <= '0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    car_red    = '0;
    car_yellow = '0;
    car_green  = '0;
    ped_red    = '0;
    ped_green  = '0;
    if (state_q == S_OFF) begin
      car_yellow = {N_PHASES{blink_q}};
    end else begin
      for (int a = 0; a < N_PHASES; a++) begin
        if (PW'(a) != phase_q) begin
          car_red[a] = 1'b1;
        end else begin
          unique case (1'b1)
            (state_q == S_ALL_RED): car_red[a] = 1'b1;
            (state_q == S_RED_YELLOW): begin
              car_red[a]    = 1'b1;
              car_yellow[a] = 1'b1;
            end
            (state_q == S_GREEN):       car_green[a]  = 1'b1;
            (state_q == S_GREEN_BLINK): car_green[a]  = blink_q;
            (state_q == S_YELLOW):      car_yellow[a] = 1'b1;
            default: car_red[a] = 1'b1;
          endcase
        end
      end
      for (int k = 0; k < N_PHASES; k++) begin
        if (walk[k]) begin
          ped_green[k] = (state_q == S_GREEN) ? 1'b1 : blink_q;
        end else begin
          ped_red[k] = 1'b1;
        end
      end
    end
  end

  assign rem_full = dur_q - timer_q;

  always_comb begin
    rem_ticks = 8'd0;
    if (state_q != S_OFF) begin
      rem_ticks = (rem_full > TW'(255)) ? 8'hff : rem_full[7:0];
    end
  end

  assign active_phase = phase_q;
  assign req_pending  = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised bench for traffic_phase_ctrl against a tick-level lamp model.
// Directed runs cover debounce edges, early green, walk lockout and resets.
module tb_traffic_phase_ctrl;

  localparam int N   = 3;
  localparam int TAR = 2;
  localparam int TRY = 2;
  localparam int TG  = 6;
  localparam int TMG = 3;
  localparam int TGB = 4;
  localparam int TY  = 2;
  localparam int BH  = 2;
  localparam int DC  = 50;
  localparam int PW  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] ped_req = '0;

  logic [N-1:0]  car_red, car_yellow, car_green;
  logic [N-1:0]  ped_red, ped_green, req_pending;
  logic [PW-1:0] active_phase;
  logic [7:0]    rem_ticks;

  traffic_phase_ctrl #(
    .N_PHASES(N), .T_ALL_RED(TAR), .T_RED_YELLOW(TRY),
    .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_GREEN_BLINK(TGB),
    .T_YELLOW(TY), .BLINK_HALF(BH), .DEBOUNCE_CYC(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
    .ped_req(ped_req), .car_red(car_red), .car_yellow(car_yellow),
    .car_green(car_green), .ped_red(ped_red), .ped_green(ped_green),
    .active_phase(active_phase), .rem_ticks(rem_ticks),
    .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gcnt  = 0;

  // Model: step 0..4 = all-red, red-yellow, green, green-blink, yellow.
  int dur [5] = '{TAR, TRY, TG, TGB, TY};
  bit m_off;
  int m_step, m_el, m_ph, m_bc;
  bit m_blink;
  bit m_pend [N];
  int m_dcnt [N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int srv_of(input int k);
    return (k + 1) % N;
  endfunction

  task automatic model_reset();
    m_off = 1'b1; m_step = 0; m_el = 0; m_ph = 0;
    m_bc = 0; m_blink = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_dcnt[k] = 0;
    end
  endtask

  task automatic blink_adv();
    m_bc++;
    if (m_bc == BH) begin
      m_bc = 0;
      m_blink = !m_blink;
    end
  endtask

  task automatic model_step(input bit t, input bit en, input logic [N-1:0] req);
    bit np [N];
    bit others;
    bit wk;
    for (int k = 0; k < N; k++) begin
      wk = !m_off && (m_step == 2 || m_step == 3) && m_ph == srv_of(k);
      np[k] = m_pend[k] || (m_dcnt[k] >= DC && !m_off && !wk);
      m_dcnt[k] = req[k] ? ((m_dcnt[k] < DC) ? m_dcnt[k] + 1 : DC) : 0;
    end
    if (t) begin
      if (m_off) begin
        if (en) begin
          m_off = 1'b0; m_step = 0; m_el = 0; m_ph = 0;
          m_blink = 1'b0; m_bc = 0;
        end else begin
          blink_adv();
        end
      end else if (!en) begin
        m_off = 1'b1; m_step = 0; m_el = 0; m_ph = 0;
        m_blink = 1'b0; m_bc = 0;
        for (int k = 0; k < N; k++) np[k] = 1'b0;
      end else begin
        others = 1'b0;
        for (int k = 0; k < N; k++)
          if (m_pend[k] && srv_of(k) != m_ph) others = 1'b1;
        if (m_el + 1 == dur[m_step] ||
            (m_step == 2 && m_el + 1 >= TMG && others)) begin
          if (m_step == 1)
            for (int k = 0; k < N; k++)
              if (srv_of(k) == m_ph) np[k] = 1'b0;
          if (m_step == 4) m_ph = (m_ph + 1) % N;
          m_step = (m_step + 1) % 5;
          m_el = 0;
          m_blink = 1'b0; m_bc = 0;
        end else begin
          m_el++;
          if (m_step == 3) blink_adv();
          else begin
            m_blink = 1'b0; m_bc = 0;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) m_pend[k] = np[k];
  endtask

  function automatic logic [5*N-1:0] exp_lamps();
    logic [N-1:0] cr, cy, cg, pr, pg;
    cr = '0; cy = '0; cg = '0; pr = '0; pg = '0;
    if (m_off) begin
      cy = {N{m_blink}};
    end else begin
      for (int a = 0; a < N; a++) begin
        if (a != m_ph) cr[a] = 1'b1;
        else case (m_step)
          0: cr[a] = 1'b1;
          1: begin cr[a] = 1'b1; cy[a] = 1'b1; end
          2: cg[a] = 1'b1;
          3: cg[a] = m_blink;
          default: cy[a] = 1'b1;
        endcase
      end
      for (int k = 0; k < N; k++) begin
        if (srv_of(k) == m_ph && m_step == 2) pg[k] = 1'b1;
        else if (srv_of(k) == m_ph && m_step == 3) pg[k] = m_blink;
        else pr[k] = 1'b1;
      end
    end
    return {cr, cy, cg, pr, pg};
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  function automatic int exp_rem();
    int r;
    if (m_off) return 0;
    r = dur[m_step] - m_el;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic cyc(input bit t, input bit en, input logic [N-1:0] req);
    if (t && car_green[0]) gcnt++;
    tick = t;
    enable = en;
    ped_req = req;
    model_step(t, en, req);
    @(negedge clk);
    chk("lamps", {car_red, car_yellow, car_green, ped_red, ped_green},
        exp_lamps());
    chk("phase", active_phase, m_ph);
    chk("rem", rem_ticks, exp_rem());
    chk("pend", req_pending, pend_vec());
  endtask

  task automatic run_until(input int st, input int ph, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!m_off && m_step == st && m_ph == ph) begin
        hit = 1'b1;
        break;
      end
      cyc(1'b1, 1'b1, '0);
    end
    if (!hit) chk("run_timeout", 0, 1);
  endtask

  task automatic green_run();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!car_green[0]) begin
        done = 1'b1;
        break;
      end
      cyc(1'b1, 1'b1, '0);
    end
    if (!done) chk("green_timeout", 0, 1);
  endtask

  initial begin
    bit en;
    int hold;
    logic [N-1:0] rq;

    model_reset();
    #1;
    chk("rst_lamps", {car_red, car_yellow, car_green, ped_red, ped_green}, 0);
    chk("rst_phase", active_phase, 0);
    chk("rst_rem", rem_ticks, 0);
    chk("rst_pend", req_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (12) cyc(1'b1, 1'b0, '0);
    repeat (60) cyc(1'b0, 1'b0, 3'b001);
    cyc(1'b0, 1'b0, '0);
    chk("off_nolatch", req_pending, 0);

    cyc(1'b1, 1'b1, '0);
    chk("start_phase", active_phase, 0);
    chk("start_red", car_red, 3'b111);
    chk("start_rem", rem_ticks, TAR);

    repeat (49) cyc(1'b0, 1'b1, 3'b001);
    cyc(1'b0, 1'b1, '0);
    chk("deb49", req_pending, 0);
    repeat (50) cyc(1'b0, 1'b1, 3'b001);
    chk("deb50_pre", req_pending, 0);
    cyc(1'b0, 1'b1, '0);
    chk("deb50", req_pending, 3'b001);

    run_until(2, 0, 20);
    gcnt = 0;
    green_run();
    chk("early_green", gcnt, TMG);
    run_until(2, 1, 80);
    chk("served_clr", req_pending, 0);

    run_until(2, 0, 200);
    gcnt = 0;
    repeat (60) cyc(1'b0, 1'b1, 3'b100);
    cyc(1'b0, 1'b1, '0);
    green_run();
    chk("walk_full", gcnt, TG);
    chk("walk_nolatch", req_pending, 0);

    repeat (60) cyc(1'b0, 1'b1, 3'b010);
    cyc(1'b0, 1'b1, '0);
    chk("gb_pend1", req_pending, 3'b010);
    cyc(1'b1, 1'b0, '0);
    chk("dis_pend", req_pending, 0);
    chk("dis_red", car_red, 0);
    chk("dis_rem", rem_ticks, 0);
    cyc(1'b1, 1'b1, '0);
    chk("reen_phase", active_phase, 0);
    chk("reen_red", car_red, 3'b111);

    run_until(4, 0, 50);
    chk("pre_arst_y", car_yellow[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lamps", {car_red, car_yellow, car_green, ped_red, ped_green}, 0);
    chk("arst_phase", active_phase, 0);
    chk("arst_rem", rem_ticks, 0);
    model_reset();
    tick = 1'b0;
    enable = 1'b0;
    ped_req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    en = 1'b1;
    hold = 0;
    rq = '0;
    repeat (15000) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) en = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        en = 1'b0;
        hold = $urandom_range(3, 30);
      end
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 39) == 0) rq[k] = ~rq[k];
      cyc($urandom_range(0, 2) == 0, en, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
